// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared op codes, FSM encoding and byte-enable constants for dm_access
package dm_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_B0   = 4'b0001;

  function automatic logic is_store(input logic [2:0] op);
    return (op >= OP_SW);
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input logic [2:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/dm_access_load_ext.sv
// rtl/dm_access_load_ext.sv - load lane select with sign/zero extension
module load_ext
  import dm_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (addr_lo)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      2'd3: lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = word;
    case (op)
      OP_LB:   result = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  result = {24'd0, lane_b};
      OP_LH:   result = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  result = {16'd0, lane_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dm_access.sv
// rtl/dm_access.sv - MIPS M-stage data access FSM; DM_ALIGN_EXC_EN enables address-error exceptions
module dm_access
  import dm_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic [2:0]  op_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic        stall_m,
  output logic [31:0] rdata_w,
  output logic        rdata_valid,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state, state_n;
  logic [2:0]         op_q;
  logic [31:0]        addr_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic               we_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt;

  logic [31:0]        addr_eff;
  logic               align_ok;
  logic [3:0]         be_n;
  logic [31:0]        wdata_n;
  logic [31:0]        ext_word;
  logic               timeout;

`ifdef DM_ALIGN_EXC_EN
  logic misaligned;
  always_comb begin
    misaligned = (is_word(op_m) && (addr_m[1:0] != 2'b00)) ||
                 (is_half(op_m) && addr_m[0]);
    align_ok   = !misaligned;
    addr_eff   = addr_m;
  end
`else
  // Without exceptions the low bits are silently forced to the op's natural alignment.
  always_comb begin
    align_ok = 1'b1;
    addr_eff = addr_m;
    if (is_word(op_m))
      addr_eff[1:0] = 2'b00;
    else if (is_half(op_m))
      addr_eff[0] = 1'b0;
  end
`endif

  always_comb begin
    be_n    = BE_ALL;
    wdata_n = '0;
    case (op_m)
      OP_SW: wdata_n = wdata_m;
      OP_SH: begin
        be_n    = addr_eff[1] ? BE_HI : BE_LO;
        wdata_n = {2{wdata_m[15:0]}};
      end
      OP_SB: begin
        be_n    = BE_B0 << addr_eff[1:0];
        wdata_n = {4{wdata_m[7:0]}};
      end
      default: ;
    endcase
  end

  load_ext u_load_ext (
    .op      (op_q),
    .addr_lo (addr_q[1:0]),
    .word    (bus_rdata),
    .result  (ext_word)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    stall_m     = 1'b0;
    bus_req     = 1'b0;
    rdata_valid = 1'b0;
    exc_adel    = 1'b0;
    exc_ades    = 1'b0;
    timeout     = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_m) begin
          if (align_ok) begin
            stall_m = 1'b1;
            state_n = S_REQ;
          end
`ifdef DM_ALIGN_EXC_EN
          else begin
            exc_adel = !is_store(op_m);
            exc_ades = is_store(op_m);
          end
`endif
        end
      end
      S_REQ: begin
        bus_req = 1'b1;
        stall_m = 1'b1;
        if (bus_ack) begin
          state_n = S_DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        rdata_valid = !is_store(op_q);
        state_n     = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Reset must withdraw the request in the same cycle, before the register clears.
    if (reset) begin
      stall_m     = 1'b0;
      bus_req     = 1'b0;
      rdata_valid = 1'b0;
      exc_adel    = 1'b0;
      exc_ades    = 1'b0;
      timeout     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_LW;
      addr_q  <= '0;
      be_q    <= BE_NONE;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      err_q <= timeout;
      if (state == S_IDLE && valid_m && align_ok) begin
        op_q    <= op_m;
        addr_q  <= addr_eff;
        be_q    <= be_n;
        wdata_q <= wdata_n;
        we_q    <= is_store(op_m);
        cnt     <= '0;
      end
      if (state == S_REQ) begin
        cnt <= cnt + CNT_W'(1);
        if (bus_ack)
          rdata_q <= ext_word;
        else if (timeout)
          rdata_q <= '0;
      end
    end
  end

  assign rdata_w   = rdata_q;
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_dm_access.sv
// tb/tb_dm_access.sv - directed scoreboard bench for dm_access (TIMEOUT=4)
module tb_dm_access;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4,
                         SW = 3'd5, SH = 3'd6, SB = 3'd7;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m;
  logic [2:0]  op_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic        stall_m;
  logic [31:0] rdata_w;
  logic        rdata_valid;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        exc_adel;
  logic        exc_ades;
  logic        bus_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  dm_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .op_m(op_m), .addr_m(addr_m),
    .wdata_m(wdata_m), .stall_m(stall_m), .rdata_w(rdata_w), .rdata_valid(rdata_valid),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic is_ld(input logic [2:0] op);
    return op < SW;
  endfunction

  function automatic logic [31:0] m_addr(input logic [2:0] op, input logic [31:0] a);
`ifdef DM_ALIGN_EXC_EN
    return a;
`else
    if (op == LW || op == SW) return a & 32'hFFFF_FFFC;
    if (op == LH || op == LHU || op == SH) return a & 32'hFFFF_FFFE;
    return a;
`endif
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
    if (op == SH) return a[1] ? 4'b1100 : 4'b0011;
    if (op == SB) return 4'b0001 << a[1:0];
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] w);
    if (op == SH) return {w[15:0], w[15:0]};
    if (op == SB) return {w[7:0], w[7:0], w[7:0], w[7:0]};
    return w;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] sb, sh;
    sb = w >> (8 * a[1:0]);
    sh = w >> (16 * a[1]);
    case (op)
      LB:  return {{24{sb[7]}}, sb[7:0]};
      LBU: return {24'h0, sb[7:0]};
      LH:  return {{16{sh[15]}}, sh[15:0]};
      LHU: return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // waits < 0 withholds the ack so the access times out.
  task automatic access(input string name, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
    int cyc;
    logic done;
    logic [31:0] ea;
    ea = m_addr(op, addr);
    valid_m = 1'b1; op_m = op; addr_m = addr; wdata_m = wdata;
    if (is_ld(op)) exp_q.push_back(waits < 0 ? 32'h0 : m_ext(op, ea, rdata));
    #1;
    check({name, "_stall_idle"}, stall_m, 1'b1);
    check({name, "_exc"}, {exc_adel, exc_ades}, 2'b00);
    tick;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      check({name, "_req"}, bus_req, 1'b1);
      if (cyc == 0) begin
        check({name, "_addr"}, bus_addr, {ea[31:2], 2'b00});
        check({name, "_be"}, bus_be, m_be(op, ea));
        check({name, "_we"}, bus_we, !is_ld(op));
        if (!is_ld(op)) check({name, "_wdata"}, bus_wdata, m_wdata(op, wdata));
      end
      if (waits >= 0 && cyc == waits) begin
        bus_ack = 1'b1;
        bus_rdata = rdata;
      end else begin
        bus_rdata = $urandom;
      end
      tick;
      cyc++;
      bus_ack = 1'b0;
      if (!stall_m) done = 1'b1;
    end
    check({name, "_done"}, done, 1'b1);
    check({name, "_req_cycles"}, cyc, (waits < 0) ? TMO : waits + 1);
    check({name, "_err"}, bus_err, waits < 0);
    check({name, "_req_off"}, bus_req, 1'b0);
    check({name, "_rvalid"}, rdata_valid, is_ld(op));
    if (rdata_valid) begin
      if (exp_q.size() == 0) check({name, "_sb_empty"}, 1'b1, 1'b0);
      else check({name, "_rdata"}, rdata_w, exp_q.pop_front());
    end
    valid_m = 1'b0;
    tick;
    check({name, "_rvalid_pulse"}, rdata_valid, 1'b0);
    check({name, "_err_pulse"}, bus_err, 1'b0);
    check({name, "_stall_after"}, stall_m, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_stall"}, stall_m, 1'b0);
    check({name, "_rdata"}, rdata_w, 32'h0);
    check({name, "_rvalid"}, rdata_valid, 1'b0);
    check({name, "_req"}, bus_req, 1'b0);
    check({name, "_we"}, bus_we, 1'b0);
    check({name, "_addr"}, bus_addr, 32'h0);
    check({name, "_be"}, bus_be, 4'h0);
    check({name, "_wdata"}, bus_wdata, 32'h0);
    check({name, "_exc"}, {exc_adel, exc_ades}, 2'b00);
    check({name, "_err"}, bus_err, 1'b0);
  endtask

  initial begin
    reset = 1'b1; valid_m = 1'b0; op_m = LW; addr_m = '0; wdata_m = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    tick; tick;
    reset = 1'b0;
    #1;
    check_all_zero("reset");

    access("lw",  LW,  32'h10, 32'h0,         32'h8899_AABB, 0);
    access("lb",  LB,  32'h13, 32'h0,         32'h8011_2233, 0);
    access("lbu", LBU, 32'h13, 32'h0,         32'h8011_2233, 1);
    access("sh",  SH,  32'h22, 32'h0000_BEEF, 32'h0,         0);
    access("sb",  SB,  32'h21, 32'h1234_565A, 32'h0,         2);
    access("sw",  SW,  32'h30, 32'hCAFE_F00D, 32'h0,         3);
    access("lh",  LH,  32'h12, 32'h0,         32'h8001_1234, 0);
    access("lhu", LHU, 32'h16, 32'h0,         32'h8001_1234, 1);
    access("lh0", LH,  32'h14, 32'h0,         32'h8001_7FFE, 0);
    access("tmo", LW,  32'h40, 32'h0,         32'h1111_2222, -1);

    // Ack while idle is ignored.
    bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    tick;
    bus_ack = 1'b0;
    check("idle_ack_req", bus_req, 1'b0);
    check("idle_ack_rvalid", rdata_valid, 1'b0);
    check("idle_ack_stall", stall_m, 1'b0);

`ifdef DM_ALIGN_EXC_EN
    valid_m = 1'b1; op_m = LW; addr_m = 32'h11;
    #1;
    check("mis_lw_adel", exc_adel, 1'b1);
    check("mis_lw_ades", exc_ades, 1'b0);
    check("mis_lw_stall", stall_m, 1'b0);
    tick;
    valid_m = 1'b0;
    #1;
    check("mis_lw_req", bus_req, 1'b0);
    check("mis_lw_adel_off", exc_adel, 1'b0);
    valid_m = 1'b1; op_m = SH; addr_m = 32'h23;
    #1;
    check("mis_sh_ades", exc_ades, 1'b1);
    check("mis_sh_adel", exc_adel, 1'b0);
    tick;
    valid_m = 1'b0;
    #1;
    check("mis_sh_req", bus_req, 1'b0);
`else
    access("mis_lw", LW, 32'h11, 32'h0,         32'hA1B2_C3D4, 0);
    access("mis_sh", SH, 32'h23, 32'h0000_1357, 32'h0,         0);
`endif

    // Reset during REQ.
    valid_m = 1'b1; op_m = SW; addr_m = 32'h44; wdata_m = 32'h0BAD_F00D;
    tick;
    check("rst_req_before", bus_req, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_req_immediate", bus_req, 1'b0);
    tick;
    reset = 1'b0; valid_m = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick;
    check("rst_stays_idle", bus_req, 1'b0);

    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
